mps_intl_manager: RTL and testbench
===================================

// Module: mps_intl_manager
// PURPOSE
//  Interlock manager for the MPS system: synchronises, debounces, masks and latches all fault sources
//  (analog intl, ext DI faults, PWM faults, OC trip) and records the first fault. Drives the latched
//  interlock flag to the MPS system FSM. Runs the interlock-clear sequence: pulse o_intl_clr /
//  o_intl_OC_rst, wait for settle, verify the sources, then release. Sits between the I/O and the MPS FSM.
// PARAMETERS
//  N_SRC      28    number of fault sources (17 analog + 6 ext DI + 4 PWM + 1 OC)
//  DB_W       16    debounce counter width
//  CLR_PULSE  200   o_intl_clr / o_intl_OC_rst pulse length, cycles (1 us @ 200 MHz)
//  SETTLE     2000  post-pulse settle time before verify, cycles
// PORTS
//  i_clk          in   1      system clock
//  i_rst          in   1      reset, asynchronous, active-low
//  i_src          in   N_SRC  raw fault sources, 1 = fault, asynchronous to i_clk
//  i_mask         in   N_SRC  1 = source enabled for latching (AXI register)
//  i_db_len       in   DB_W   debounce length in cycles, common to all sources (AXI register)
//  i_clr_req      in   1      single-cycle interlock-clear request (AXI)
//  o_intl_flag    out  1      |o_intl_latch, registered; feeds the MPS FSM interlock input
//  o_intl_latch   out  N_SRC  latched faults
//  o_first_idx    out  5      index of the first latched fault
//  o_first_vld    out  1      o_first_idx valid
//  o_intl_clr     out  1      interlock-clear pulse to the fault hardware
//  o_intl_OC_rst  out  1      OC trip reset pulse
//  o_clr_busy     out  1      clear sequence in progress
//  o_clr_fail     out  1      sticky: last clear failed verify
//  o_state        out  2      FSM state, for status readback
// BEHAVIOUR
//  Reset: all outputs 0, FSM = ST_MON, debounce counters 0, sync flops 0.
//  Sync: 2-FF synchroniser per source -> s_src.
//  Debounce, per source: cnt clears when s_src=0, otherwise increments and saturates.
//   qual = s_src & (cnt >= i_db_len); i_db_len=0 -> qual on the first synchronised-high cycle.
//   Latency from raw edge to latch: 2 + i_db_len + 1 cycles; o_intl_flag follows 1 cycle later.
//  Latch: in ST_MON only, latch[i] <= latch[i] | (qual[i] & i_mask[i]).
//   A latched bit holds until a successful clear; de-asserting its mask does not clear it.
//   If the source is deasserted, the bit still holds.
//  First fault: captured on the cycle o_first_vld goes 0->1. Simultaneous new faults: lowest index wins.
//   Later faults never overwrite it.
//  FSM (2-bit encoding from the package):
//   ST_MON(0)    : on i_clr_req -> ST_PULSE, clear o_clr_fail, set o_clr_busy.
//                  i_clr_req is accepted even with no latch set, so the OC hardware still gets its reset.
//   ST_PULSE(1)  : o_intl_clr = o_intl_OC_rst = 1 for exactly CLR_PULSE cycles -> ST_SETTLE.
//   ST_SETTLE(2) : both pulses 0, wait SETTLE cycles -> ST_CHECK.
//   ST_CHECK(3)  : one cycle.
//                  If |(s_src & i_mask) == 0: clear latch, o_first_vld, o_intl_flag.
//                  Otherwise: keep the latches and set o_clr_fail.
//                  Either way -> ST_MON and drop o_clr_busy.
//  In ST_PULSE/ST_SETTLE/ST_CHECK, new qualifications do not latch. Sources still active are caught by
//   the verify in ST_CHECK; sources re-qualifying after the return to ST_MON latch normally.
//  i_clr_req outside ST_MON is ignored (no queueing).
//  The timer is a single shared counter of $clog2(max(CLR_PULSE,SETTLE)) bits, reloaded on each state entry.
//  i_db_len changing mid-count takes effect immediately (compare, not reload).
//  Reset mid-sequence: pulses drop asynchronously; everything returns to reset values.
// STRUCTURE
//  Package mps_intl_pkg:
//   state typedef/localparams ST_MON..ST_CHECK.
//   source index constants: SRC_ANA0=0..16, SRC_EXT0=17 (ext_di[0]), SRC_EXT4..8=18..22,
//    SRC_PWM0..3=23..26, SRC_OC=27.
//  Sub-module mps_intl_debounce: sync + counter + qual for one source, instantiated N_SRC times via generate.
//  The top holds the latch, the first-fault priority encoder, the FSM and the timer.
// TESTING
//  1 i_db_len=10, src[3] high 12 cycles, mask all 1:
//     -> latch[3]=1 at cycle 13, o_intl_flag at 14, o_first_idx=3, o_first_vld=1.
//  2 i_db_len=10, src[5] high for 8 cycles then low:
//     -> no latch, o_intl_flag stays 0.
//  3 src[7] and src[2] qualify in the same cycle:
//     -> latch=0x84, o_first_idx=2; a later src[1] fault leaves o_first_idx=2.
//  4 Latched src[27] and source released, i_clr_req:
//     -> o_intl_clr/o_intl_OC_rst high exactly 200 cycles, o_clr_busy high 200+2000+1 cycles,
//        latch cleared, o_clr_fail=0.
//  5 Latched src[0], source still high, i_clr_req:
//     -> latch kept, o_clr_fail=1, state back to 0; a second i_clr_req mid-PULSE is ignored.
//  6 i_mask[4]=0 with src[4] high:
//     -> no latch and the clear verify passes.
//     Assert i_rst during ST_SETTLE -> all outputs 0 immediately.

Source files
------------

// File: rtl/mps_intl_pkg.sv
// Shared types and constants for the MPS interlock manager: FSM state encoding
// and the fixed fault-source index map.
package mps_intl_pkg;

  typedef enum logic [1:0] {
    ST_MON    = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  localparam int unsigned SRC_ANA0 = 0;
  localparam int unsigned SRC_EXT0 = 17;
  localparam int unsigned SRC_EXT4 = 18;
  localparam int unsigned SRC_EXT5 = 19;
  localparam int unsigned SRC_EXT6 = 20;
  localparam int unsigned SRC_EXT7 = 21;
  localparam int unsigned SRC_EXT8 = 22;
  localparam int unsigned SRC_PWM0 = 23;
  localparam int unsigned SRC_PWM1 = 24;
  localparam int unsigned SRC_PWM2 = 25;
  localparam int unsigned SRC_PWM3 = 26;
  localparam int unsigned SRC_OC   = 27;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mps_intl_manager_if.sv
// Register/status bundle between the AXI/I-O side and the interlock manager.
interface mps_intl_manager_if #(
  parameter int unsigned N_SRC = 28,
  parameter int unsigned DB_W  = 16
);
  logic [N_SRC-1:0] i_src;
  logic [N_SRC-1:0] i_mask;
  logic [DB_W-1:0]  i_db_len;
  logic             i_clr_req;
  logic             o_intl_flag;
  logic [N_SRC-1:0] o_intl_latch;
  logic [4:0]       o_first_idx;
  logic             o_first_vld;
  logic             o_intl_clr;
  logic             o_intl_OC_rst;
  logic             o_clr_busy;
  logic             o_clr_fail;
  logic [1:0]       o_state;

  modport master (
    output i_src, i_mask, i_db_len, i_clr_req,
    input  o_intl_flag, o_intl_latch, o_first_idx, o_first_vld,
           o_intl_clr, o_intl_OC_rst, o_clr_busy, o_clr_fail, o_state
  );

  modport slave (
    input  i_src, i_mask, i_db_len, i_clr_req,
    output o_intl_flag, o_intl_latch, o_first_idx, o_first_vld,
           o_intl_clr, o_intl_OC_rst, o_clr_busy, o_clr_fail, o_state
  );
endinterface

// File: rtl/mps_intl_debounce.sv
// One fault source: 2-FF synchroniser, saturating high-time counter and
// qualification against the shared debounce length.
module mps_intl_debounce #(
  parameter int unsigned DB_W = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_src,
  input  logic [DB_W-1:0] i_db_len,
  output logic            o_s_src,
  output logic            o_qual
);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q)
      cnt_d = '0;
    else if (cnt_q != '1)
      cnt_d = cnt_q + DB_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_src;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Compared live so a new i_db_len applies to counts already in progress.
  assign o_s_src = sync2_q;
  assign o_qual  = sync2_q && (cnt_q >= i_db_len);

endmodule

// File: rtl/mps_intl_manager.sv
// Interlock manager: latches debounced, masked faults, records the first one
// and runs the pulse / settle / verify clear sequence.
module mps_intl_manager
  import mps_intl_pkg::*;
#(
  parameter int unsigned N_SRC     = 28,
  parameter int unsigned DB_W      = 16,
  parameter int unsigned CLR_PULSE = 200,
  parameter int unsigned SETTLE    = 2000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mps_intl_manager_if.slave intl
);

  localparam int unsigned TMR_W = $clog2(max_u(CLR_PULSE, SETTLE));

  logic [N_SRC-1:0] s_src, qual, new_flt;
  logic [4:0]       first_idx_c;

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [N_SRC-1:0] latch_q;
  logic [4:0]       first_idx_q;
  logic             first_vld_q, flag_q, pulse_q, busy_q, fail_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_db
    mps_intl_debounce #(.DB_W(DB_W)) u_db (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_src    (intl.i_src[g]),
      .i_db_len (intl.i_db_len),
      .o_s_src  (s_src[g]),
      .o_qual   (qual[g])
    );
  end

  assign new_flt = qual & intl.i_mask;

  // Descending scan so the lowest simultaneous index is the one left standing.
  always_comb begin
    first_idx_c = '0;
    for (int unsigned i = N_SRC; i > 0; i--)
      if (new_flt[i-1]) first_idx_c = 5'(i - 1);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_MON;
      tmr_q       <= '0;
      latch_q     <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      flag_q      <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      flag_q <= |latch_q;
      case (state_q)
        ST_MON: begin
          latch_q <= latch_q | new_flt;
          if (!first_vld_q && (|new_flt)) begin
            first_vld_q <= 1'b1;
            first_idx_q <= first_idx_c;
          end
          if (intl.i_clr_req) begin
            state_q <= ST_PULSE;
            tmr_q   <= TMR_W'(CLR_PULSE - 1);
            pulse_q <= 1'b1;
            busy_q  <= 1'b1;
            fail_q  <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (tmr_q == '0) begin
            state_q <= ST_SETTLE;
            tmr_q   <= TMR_W'(SETTLE - 1);
            pulse_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        ST_SETTLE: begin
          if (tmr_q == '0)
            state_q <= ST_CHECK;
          else
            tmr_q <= tmr_q - TMR_W'(1);
        end
        ST_CHECK: begin
          state_q <= ST_MON;
          busy_q  <= 1'b0;
          // Verify on the synchronised raw sources, not the debounced ones.
          if (|(s_src & intl.i_mask)) begin
            fail_q <= 1'b1;
          end else begin
            latch_q     <= '0;
            first_vld_q <= 1'b0;
            first_idx_q <= '0;
            flag_q      <= 1'b0;
          end
        end
        default: state_q <= ST_MON;
      endcase
    end
  end

  assign intl.o_intl_flag   = flag_q;
  assign intl.o_intl_latch  = latch_q;
  assign intl.o_first_idx   = first_idx_q;
  assign intl.o_first_vld   = first_vld_q;
  assign intl.o_intl_clr    = pulse_q;
  assign intl.o_intl_OC_rst = pulse_q;
  assign intl.o_clr_busy    = busy_q;
  assign intl.o_clr_fail    = fail_q;
  assign intl.o_state       = state_q;

endmodule

// File: tb/tb_mps_intl_manager.sv
// Bench for mps_intl_manager: table of single-source latch vectors plus
// hand-written clear-sequence, priority and reset sequences.
module tb_mps_intl_manager;

  localparam logic [27:0] ALL = 28'hFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mps_intl_manager_if #(.N_SRC(28), .DB_W(16)) bus ();

  mps_intl_manager #(
    .N_SRC(28), .DB_W(16), .CLR_PULSE(200), .SETTLE(2000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .intl  (bus)
  );

  typedef struct {
    logic [15:0] db;
    logic [27:0] mask;
    int          bitn;
    int          hold;
    logic [27:0] exp_latch;
    logic [4:0]  exp_idx;
    logic        exp_vld;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    logic [27:0] latch;
    logic [4:0]  idx;
    logic        vld;
    int          cyc;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [40:0] all_outs();
    return {bus.o_intl_flag, bus.o_intl_latch, bus.o_first_idx, bus.o_first_vld,
            bus.o_intl_clr, bus.o_intl_OC_rst, bus.o_clr_busy, bus.o_clr_fail, bus.o_state};
  endfunction

  task automatic do_reset();
    bus.i_src     = '0;
    bus.i_mask    = ALL;
    bus.i_db_len  = '0;
    bus.i_clr_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Issues one clear request and follows it until o_clr_busy drops.
  task automatic run_clear(input int reissue_at, input int glitch_at,
                           output int busy_n, output int clr_n, output int oc_n,
                           output logic [1:0] st_first, output logic [1:0] st_mid,
                           output logic [1:0] st_last, output logic done);
    busy_n = 0; clr_n = 0; oc_n = 0; done = 1'b0;
    st_first = 2'd0; st_mid = 2'd0; st_last = 2'd0;
    bus.i_clr_req = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tick();
      bus.i_clr_req = 1'b0;
      if (!bus.o_clr_busy) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      clr_n += int'(bus.o_intl_clr);
      oc_n  += int'(bus.o_intl_OC_rst);
      if (busy_n == 1)    st_first = bus.o_state;
      if (busy_n == 1000) st_mid   = bus.o_state;
      st_last = bus.o_state;
      if (busy_n == reissue_at) bus.i_clr_req = 1'b1;
      if (glitch_at != 0 && busy_n == glitch_at)     bus.i_src[3] = 1'b1;
      if (glitch_at != 0 && busy_n == glitch_at + 3) bus.i_src[3] = 1'b0;
    end
  endtask

  initial begin
    int         lat, flg, bn, cn, on;
    logic [1:0] s1, s2, s3;
    logic       done;
    exp_t       e;

    vecs[0] = '{16'd10, ALL,           3,  12, 28'h000_0008,  5'd3,  1'b1, 13};
    vecs[1] = '{16'd10, ALL,           5,  8,  28'h000_0000,  5'd0,  1'b0, 0};
    vecs[2] = '{16'd0,  ALL,           9,  1,  28'h000_0200,  5'd9,  1'b1, 3};
    vecs[3] = '{16'd3,  ALL,           27, 10, 28'h800_0000,  5'd27, 1'b1, 6};
    vecs[4] = '{16'd2,  28'hFFF_FFEF,  4,  10, 28'h000_0000,  5'd0,  1'b0, 0};
    vecs[5] = '{16'd5,  ALL,           0,  6,  28'h000_0001,  5'd0,  1'b1, 8};
    vecs[6] = '{16'd5,  ALL,           0,  5,  28'h000_0000,  5'd0,  1'b0, 0};

    rst_n = 1'b0;
    bus.i_src = '0; bus.i_mask = ALL; bus.i_db_len = '0; bus.i_clr_req = 1'b0;
    #1;
    check("reset_outputs", 64'(all_outs()), 64'd0);

    // Table: one source per vector, latch timing and first-fault capture.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      bus.i_db_len = vecs[v].db;
      bus.i_mask   = vecs[v].mask;
      bus.i_src[vecs[v].bitn] = 1'b1;
      sb_q.push_back('{vecs[v].exp_latch, vecs[v].exp_idx, vecs[v].exp_vld, vecs[v].exp_cyc});
      lat = 0; flg = 0;
      for (int c = 1; c <= 20; c++) begin
        tick();
        if (c == vecs[v].hold) bus.i_src = '0;
        if (lat == 0 && (|bus.o_intl_latch)) lat = c;
        if (flg == 0 && bus.o_intl_flag) flg = c;
      end
      e = sb_q.pop_front();
      check($sformatf("v%0d_latch", v), 64'(bus.o_intl_latch), 64'(e.latch));
      check($sformatf("v%0d_first_idx", v), 64'(bus.o_first_idx), 64'(e.idx));
      check($sformatf("v%0d_first_vld", v), 64'(bus.o_first_vld), 64'(e.vld));
      check($sformatf("v%0d_latch_cycle", v), 64'(lat), 64'(e.cyc));
      check($sformatf("v%0d_flag_cycle", v), 64'(flg), 64'((e.cyc == 0) ? 0 : e.cyc + 1));
    end

    // Simultaneous qualification: lowest index wins, later faults don't overwrite.
    do_reset();
    bus.i_db_len = 16'd2;
    bus.i_src[7] = 1'b1;
    bus.i_src[2] = 1'b1;
    repeat (8) tick();
    check("simul_latch", 64'(bus.o_intl_latch), 64'h84);
    check("simul_first_idx", 64'(bus.o_first_idx), 64'd2);
    bus.i_src[1] = 1'b1;
    repeat (8) tick();
    check("later_latch", 64'(bus.o_intl_latch), 64'h86);
    check("later_first_idx", 64'(bus.o_first_idx), 64'd2);

    // Clear pass on OC source; mask drop keeps latch; glitch in SETTLE must not latch.
    do_reset();
    bus.i_src[27] = 1'b1;
    repeat (3) tick();
    bus.i_src[27] = 1'b0;
    repeat (5) tick();
    check("oc_latched", 64'(bus.o_intl_latch), 64'h800_0000);
    bus.i_mask[27] = 1'b0;
    repeat (3) tick();
    check("mask_drop_holds", 64'(bus.o_intl_latch), 64'h800_0000);
    bus.i_mask = ALL;
    run_clear(0, 500, bn, cn, on, s1, s2, s3, done);
    check("pass_done", 64'(done), 64'd1);
    check("pass_clr_len", 64'(cn), 64'd200);
    check("pass_oc_len", 64'(on), 64'd200);
    check("pass_busy_len", 64'(bn), 64'd2201);
    check("pass_states", 64'({s1, s2, s3}), 64'({2'd1, 2'd2, 2'd3}));
    check("pass_after", 64'(all_outs()), 64'd0);

    // Clear fail: source still high, second request mid-PULSE ignored.
    do_reset();
    bus.i_src[0] = 1'b1;
    repeat (6) tick();
    run_clear(50, 0, bn, cn, on, s1, s2, s3, done);
    check("fail_done", 64'(done), 64'd1);
    check("fail_busy_len", 64'(bn), 64'd2201);
    check("fail_clr_len", 64'(cn), 64'd200);
    check("fail_clr_fail", 64'(bus.o_clr_fail), 64'd1);
    check("fail_latch_kept", 64'(bus.o_intl_latch), 64'h1);
    check("fail_flag_kept", 64'({bus.o_intl_flag, bus.o_first_vld}), 64'b11);
    check("fail_state", 64'(bus.o_state), 64'd0);
    repeat (4) tick();
    check("fail_no_restart", 64'({bus.o_clr_busy, bus.o_state}), 64'd0);
    bus.i_src[0] = 1'b0;
    repeat (4) tick();
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    check("fail_cleared_on_req", 64'({bus.o_clr_fail, bus.o_clr_busy}), 64'b01);
    repeat (2300) tick();
    check("retry_pass", 64'(all_outs()), 64'd0);

    // Masked source: no latch, verify passes; then reset mid-SETTLE.
    do_reset();
    bus.i_mask[4] = 1'b0;
    bus.i_src[4]  = 1'b1;
    repeat (10) tick();
    check("masked_no_latch", 64'({bus.o_intl_latch, bus.o_intl_flag}), 64'd0);
    run_clear(0, 0, bn, cn, on, s1, s2, s3, done);
    check("masked_verify", 64'({done, bus.o_clr_fail, bus.o_state}), 64'({1'b1, 1'b0, 2'd0}));
    bus.i_src[6] = 1'b1;
    repeat (3) tick();
    bus.i_src[6] = 1'b0;
    repeat (3) tick();
    check("pre_rst_latch", 64'(bus.o_intl_latch), 64'h40);
    bus.i_clr_req = 1'b1;
    tick();
    bus.i_clr_req = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (bus.o_state == 2'd2) begin
        done = 1'b1;
        break;
      end
    end
    check("reach_settle", 64'(done), 64'd1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_settle", 64'(all_outs()), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 64'(all_outs()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
